// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 subset control sequencer.
// Steps fetch/decode/execute/memory/writeback over a shared datapath.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 iord,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 reg_write,
  output logic [1:0]           mem_to_reg,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_src,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // Wait counter counts 0..MEM_TIMEOUT-1; the last value is the final try.
  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t                 state;
  logic [CW-1:0]          wait_cnt;
  logic [INSTRET_W-1:0]   retired;
  logic [1:0]             code_q;
  logic                   wait_expired;
  logic                   retire_now;

  // Final wait cycle with no response; a late mem_ready still wins.
  always_comb begin
    wait_expired = !mem_ready && (wait_cnt == WAIT_LAST);
  end

  // Retire on the exit edge of each instruction's last state.
  always_comb begin
    retire_now = 1'b0;
    case (state)
      S_ALU_WB,
      S_MEM_WB,
      S_BRANCH,
      S_JAL:       retire_now = 1'b1;
      S_MEM_WRITE: retire_now = mem_ready;
      default:     retire_now = 1'b0;
    endcase
  end

  // State sequencing, memory wait timer, fault capture and instret.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
      code_q   <= FC_NONE;
    end else begin
      wait_cnt <= '0;
      if (retire_now) begin
        retired <= retired + INSTRET_W'(1);
      end
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (wait_expired) begin
            state <= S_FAULT;
            if (code_q == FC_NONE) code_q <= FC_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_R:   state <= S_EXEC_R;
            OP_I:   state <= S_EXEC_I;
            OP_LW,
            OP_SW:  state <= S_MEM_ADDR;
            OP_BEQ: state <= S_BRANCH;
            OP_JAL: state <= S_JAL;
            default: begin
              state <= S_FAULT;
              if (code_q == FC_NONE) code_q <= FC_ILLEGAL;
            end
          endcase
        end
        S_EXEC_R:   state <= S_ALU_WB;
        S_EXEC_I:   state <= S_ALU_WB;
        S_ALU_WB:   state <= S_FETCH;
        S_MEM_ADDR: begin
          state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          if (mem_ready) begin
            state <= S_MEM_WB;
          end else if (wait_expired) begin
            state <= S_FAULT;
            if (code_q == FC_NONE) code_q <= FC_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WRITE: begin
          if (mem_ready) begin
            state <= S_FETCH;
          end else if (wait_expired) begin
            state <= S_FAULT;
            if (code_q == FC_NONE) code_q <= FC_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_FETCH;
        S_FAULT:    state <= S_FAULT;
        default: begin
          state <= S_FAULT;
          if (code_q == FC_NONE) code_q <= FC_ILLEGAL;
        end
      endcase
    end
  end

  // Control decode from the state; reset forces every output low.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 1'b0;
    fault      = 1'b0;
    fault_code = FC_NONE;
    instret    = '0;
    state_dbg  = 4'd0;
    if (!reset) begin
      fault_code = code_q;
      instret    = retired;
      state_dbg  = state;
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b00;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b00;
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MEM_WRITE: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b00;
          alu_op    = 2'b01;
          pc_src    = 1'b1;
          pc_write  = alu_zero;
        end
        S_JAL: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b10;
          pc_write   = 1'b1;
          pc_src     = 1'b1;
        end
        S_FAULT: fault = 1'b1;
        default: fault = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32 subset R-type, LW, SW, BEQ, I-type ALU and JAL. It steps a shared datapath (one ALU, one unified memory port, IR, PC, ALUOut) through fetch, decode, execute, memory and writeback states. It replaces the single-cycle opcode decoder when the core is built multi-cycle, waits on a ready/request memory handshake, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory state waits for mem_ready before faulting (≥1)
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  7  IR[6:0], stable from DECODE until FETCH
alu_zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
pc_write  out  1  load PC
ir_write  out  1  load IR from memory read data
iord  out  1  0: memory address=PC; 1: address=ALUOut
mem_req  out  1  memory request valid
mem_we  out  1  write strobe (valid with mem_req)
reg_write  out  1  register-file write enable
mem_to_reg  out  2  00 ALUOut, 01 memory data, 10 PC (already PC+4)
alu_src_a  out  2  00 PC, 01 old PC (PC of current instr), 10 rs1
alu_src_b  out  2  00 rs2, 01 const 4, 10 immediate
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
pc_src  out  1  0: ALU result; 1: ALUOut
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
instret  out  INSTRET_W  retired-instruction count, wraps modulo 2^INSTRET_W
state_dbg  out  4  current state encoding

Behaviour:
- Moore outputs decoded from the state register; pc_write and ir_write also depend on mem_ready/alu_zero as listed. Unlisted outputs are 0.
- While reset=1: all outputs 0, instret=0, fault_code=00. Next edge sets state=FETCH and clears the wait counter.
- FETCH (0): mem_req=1, iord=0, a=00, b=01, alu_op=00. If mem_ready, assert ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE (1): a=01, b=10, alu_op=00 (branch/jump target into ALUOut). Next state by opcode: 0110011→EXEC_R, 0010011→EXEC_I, 0000011/0100011→MEM_ADDR, 1100011→BRANCH, 1101111→JAL, any other→FAULT with code 01.
- EXEC_R (2): a=10, b=00, alu_op=10, then ALU_WB.
- EXEC_I (3): a=10, b=10, alu_op=10, then ALU_WB.
- ALU_WB (4): reg_write=1, mem_to_reg=00, then FETCH. Retires.
- MEM_ADDR (5): a=10, b=10, alu_op=00. Goes to MEM_READ if opcode=LW, else MEM_WRITE.
- MEM_READ (6): mem_req=1, iord=1, mem_we=0. On mem_ready go to MEM_WB.
- MEM_WB (7): reg_write=1, mem_to_reg=01, then FETCH. Retires.
- MEM_WRITE (8): mem_req=1, iord=1, mem_we=1. On mem_ready go to FETCH. Retires.
- BRANCH (9): a=10, b=00, alu_op=01, pc_src=1, pc_write=alu_zero, then FETCH. Retires whether taken or not.
- JAL (10): reg_write=1, mem_to_reg=10, pc_write=1, pc_src=1, then FETCH. Retires. reg_write and pc_write occur in the same cycle; the RF samples the old PC value.
- FAULT (15): all control outputs 0, fault=1. Stays until reset. Only the first fault code is recorded.
- Memory wait counter:
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE; increments each cycle those states see mem_ready=0.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0: go to FAULT with code 10, mem_req drops next cycle.
  - mem_ready in the same cycle the counter hits the limit counts as success.
- mem_req stays asserted and address/strobe stay stable until mem_ready. mem_ready outside a request is ignored.
- instret increments by exactly 1 on the exit edge of each retiring state. Wraps from all-ones to 0.
- Reset mid-operation (including during a memory wait or FAULT): the next cycle is FETCH with counters cleared. No partial retire.
- Unused state encodings go to FAULT with code 01.
- Nominal CPI with zero-wait memory: R/I=4, LW=5, SW=4, BEQ=3, JAL=3.

Test Plan:
- addi (0010011), mem_ready tied 1: states 0,1,3,4,0. reg_write=1 only in state 4. instret 0→1 after 4 cycles.
- LW with mem_ready delayed 3 cycles in MEM_READ: mem_req/iord held 4 cycles. MEM_WB has mem_to_reg=01. Total 8 cycles. instret+1.
- BEQ alu_zero=1 then alu_zero=0: pc_write=1 with pc_src=1 in BRANCH for the first; pc_write=0 for the second. Both increment instret.
- JAL: in state 10, reg_write=1, mem_to_reg=10, pc_write=1, pc_src=1 in the same cycle. Next state FETCH.
- Opcode 1110011: DECODE→FAULT, fault=1, fault_code=01, all strobes 0 for ≥20 cycles. Reset then returns to FETCH with fault=0.
- MEM_TIMEOUT=4, SW with mem_ready never asserted: FAULT, fault_code=10 after 4 wait cycles, instret unchanged. Separately, asserting reset in MEM_READ wait gives FETCH next cycle with instret=0.
